// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one shared memory port, with a slave-wait timeout.
// Latency: one IDLE arbitration cycle per access; backpressure: masters hold valid until ready, s_ready completes.
module mem_arbiter #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        resn,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] GNT0 = 2'b01;
   localparam logic [1:0] GNT1 = 2'b10;
   localparam logic [7:0] TMO  = 8'(TIMEOUT);

   logic [1:0] state, state_nxt;
   logic       last_grant, last_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       err_q;
   logic       cur_valid;
   logic       done;
   logic       timed_out;

   always_comb begin
      cur_valid = 1'b0;
      case (state)
         GNT0:    cur_valid = m0_valid;
         GNT1:    cur_valid = m1_valid;
         default: cur_valid = 1'b0;
      endcase
   end

   // Normal completion takes priority over a timeout landing in the same cycle.
   assign done      = cur_valid && s_ready;
   assign timed_out = cur_valid && !s_ready && (wait_cnt == TMO);

   always_comb begin
      state_nxt = state;
      last_nxt  = last_grant;
      wait_nxt  = wait_cnt;
      case (state)
         IDLE: begin
            wait_nxt = 8'd0;
            if (m0_valid && (!m1_valid || last_grant)) begin
               state_nxt = GNT0;
               last_nxt  = 1'b0;
            end else if (m1_valid) begin
               state_nxt = GNT1;
               last_nxt  = 1'b1;
            end
         end
         GNT0, GNT1: begin
            if (!cur_valid || done || timed_out) begin
               state_nxt = IDLE;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wait_cnt   <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_nxt;
         wait_cnt   <= wait_nxt;
         if (timed_out) err_q <= 1'b1;
      end
   end

   // Outputs are held at zero while reset is asserted, even before the first edge.
   always_comb begin
      s_valid     = 1'b0;
      s_instr     = 1'b0;
      s_addr      = 32'h0;
      s_wdata     = 32'h0;
      s_wstrb     = 4'h0;
      m0_ready    = 1'b0;
      m0_rdata    = 32'h0;
      m1_ready    = 1'b0;
      m1_rdata    = 32'h0;
      grant       = 2'b00;
      timeout_err = 1'b0;
      if (resn) begin
         grant       = state;
         timeout_err = err_q;
         case (state)
            GNT0: begin
               s_valid  = m0_valid && !timed_out;
               s_instr  = m0_instr;
               s_addr   = m0_addr;
               s_wdata  = m0_wdata;
               s_wstrb  = m0_wstrb;
               m0_ready = done || timed_out;
               m0_rdata = timed_out ? ERR_DATA : s_rdata;
            end
            GNT1: begin
               s_valid  = m1_valid && !timed_out;
               s_instr  = m1_instr;
               s_addr   = m1_addr;
               s_wdata  = m1_wdata;
               s_wstrb  = m1_wstrb;
               m1_ready = done || timed_out;
               m1_rdata = timed_out ? ERR_DATA : s_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a small memory model drives s_ready after a set latency,
// expected completions are queued at stimulus time and popped on each master ready pulse.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        resn;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        timeout_err;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .resn(resn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic        m;
      logic [31:0] d;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          mem_lat = 1;     // -1: memory never answers
   bit          mem_fixed = 1'b0;
   logic [31:0] mem_word = 32'h0;
   int          vcnt = 0;
   logic [1:0]  grant_q;
   logic        sr_q;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Advance one clock; memory answers when it has seen mem_lat unanswered granted cycles.
   task automatic cyc();
      #1;
      grant_q = grant;
      sr_q    = s_ready;
      @(posedge clk);
      #1;
      if (grant_q != 2'b00 && !sr_q) vcnt++;
      else vcnt = 0;
      s_ready = (mem_lat >= 0 && grant != 2'b00 && vcnt == mem_lat);
      s_rdata = !s_ready ? 32'h0 : (mem_fixed ? mem_word : mem_val(s_addr));
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      resn = 1'b0;
      m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h55; m0_wdata = 32'h1; m0_wstrb = 4'hF;
      m1_valid = 1'b1; m1_instr = 1'b1; m1_addr = 32'h66; m1_wdata = 32'h2; m1_wstrb = 4'hF;
      s_ready = 1'b0; s_rdata = 32'h0;
      repeat (3) cyc();
      s_ready = 1'b1; s_rdata = 32'h1111_2222;
      #1;
      n_cmp++;
      if ({s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got s_valid=%b s_addr=%h m0_ready=%b m0_rdata=%h want all zero",
                           s_valid, s_addr, m0_ready, m0_rdata);
      end
      n_cmp++;
      if ({grant, timeout_err} !== 3'b000) begin
         n_bad++; $display("FAIL reset_grant_err: got %b%b want 000", grant, timeout_err);
      end
      m0_valid = 1'b0; m1_valid = 1'b0; m0_instr = 1'b0; m1_instr = 1'b0;
      m0_wstrb = 4'h0; m1_wstrb = 4'h0; s_ready = 1'b0; s_rdata = 32'h0;
      resn = 1'b1;
      cyc();
      n_cmp++;
      if (grant !== 2'b00) begin
         n_bad++; $display("FAIL reset_idle_grant: got %b want 00", grant);
      end
      e = '0;
   endtask

   task automatic test_single_read();
      exp_t e;
      int   pulses = 0;
      int   at = -1;
      mem_fixed = 1'b1; mem_word = 32'h1234_5678; mem_lat = 1;
      m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0; m0_instr = 1'b0;
      sb.push_back({1'b0, 32'h1234_5678});
      cyc();
      n_cmp++;
      if ({grant, s_valid, s_addr} !== {2'b01, 1'b1, 32'h100}) begin
         n_bad++; $display("FAIL single_grant: got grant=%b s_valid=%b s_addr=%h want 01 1 00000100",
                           grant, s_valid, s_addr);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (m1_ready !== 1'b0) begin
            n_bad++; $display("FAIL single_m1_quiet: got m1_ready=%b want 0", m1_ready);
         end
         if (m0_ready === 1'b1) begin
            pulses++; at = i;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++; $display("FAIL single_sb: got m0 ready %h want nothing queued", m0_rdata);
            end else begin
               e = sb.pop_front();
               if (e !== {1'b0, m0_rdata}) begin
                  n_bad++; $display("FAIL single_rdata: got m0 %h want m%0d %h", m0_rdata, e.m, e.d);
               end
            end
         end
         cyc();
         if (pulses != 0) m0_valid = 1'b0;
      end
      n_cmp++;
      if (pulses != 1 || at != 1) begin
         n_bad++; $display("FAIL single_pulses: got %0d pulses at %0d want 1 at 1", pulses, at);
      end
      mem_fixed = 1'b0;
   endtask

   task automatic test_contention();
      exp_t       e;
      int         got = 0;
      logic [1:0] prev_g = 2'b00;
      bit         adv0 = 1'b0;
      bit         adv1 = 1'b0;
      mem_lat = 1;
      resn = 1'b0;
      m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h1000; m1_addr = 32'h2000;
      m0_wstrb = 4'h0; m1_wstrb = 4'h0;
      cyc(); cyc();
      resn = 1'b1;
      sb.push_back({1'b0, mem_val(32'h1000)});
      sb.push_back({1'b1, mem_val(32'h2000)});
      sb.push_back({1'b0, mem_val(32'h1004)});
      sb.push_back({1'b1, mem_val(32'h2004)});
      for (int i = 0; i < 40 && got < 4; i++) begin
         cyc();
         if (adv0) begin m0_addr = m0_addr + 32'd4; adv0 = 1'b0; end
         if (adv1) begin m1_addr = m1_addr + 32'd4; adv1 = 1'b0; end
         #1;
         if (i == 0) begin
            n_cmp++;
            if (grant !== 2'b01) begin
               n_bad++; $display("FAIL cont_first: got %b want 01", grant);
            end
         end
         if (prev_g != 2'b00 && grant != 2'b00 && grant != prev_g) begin
            n_cmp++; n_bad++;
            $display("FAIL cont_idle_gap: got %b directly after %b want 00 between", grant, prev_g);
         end
         prev_g = grant;
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++; $display("FAIL cont_sb: got ready m0=%b m1=%b want nothing queued", m0_ready, m1_ready);
            end else begin
               e = sb.pop_front();
               if (e !== (m0_ready ? {1'b0, m0_rdata} : {1'b1, m1_rdata})) begin
                  n_bad++; $display("FAIL cont_order: got m0r=%b m0=%h m1=%h want m%0d %h",
                                    m0_ready, m0_rdata, m1_rdata, e.m, e.d);
               end
            end
            got++;
            if (m0_ready) adv0 = 1'b1;
            else adv1 = 1'b1;
         end
      end
      n_cmp++;
      if (got != 4) begin
         n_bad++; $display("FAIL cont_count: got %0d completions want 4", got);
      end
      cyc();
      m0_valid = 1'b0; m1_valid = 1'b0;
      cyc();
   endtask

   task automatic test_write();
      exp_t e;
      int   gcyc = 0;
      bit   seen = 1'b0;
      mem_lat = 2;
      m1_valid = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011; m1_instr = 1'b0;
      sb.push_back({1'b1, mem_val(32'h40)});
      for (int i = 0; i < 12 && !seen; i++) begin
         cyc();
         if (grant === 2'b10) begin
            gcyc++;
            n_cmp++;
            if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h40, 32'hCAFE_F00D, 4'b0011}) begin
               n_bad++; $display("FAIL write_pass: got v=%b a=%h d=%h s=%b want 1 00000040 cafef00d 0011",
                                 s_valid, s_addr, s_wdata, s_wstrb);
            end
            n_cmp++;
            if (m1_ready !== s_ready || m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
               n_bad++; $display("FAIL write_ready: got m1_ready=%b s_ready=%b m0_ready=%b m0_rdata=%h",
                                 m1_ready, s_ready, m0_ready, m0_rdata);
            end
         end
         if (m1_ready === 1'b1) begin
            seen = 1'b1;
            n_cmp++;
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            if (e !== {1'b1, m1_rdata} || gcyc != 3) begin
               n_bad++; $display("FAIL write_done: got m1 %h after %0d cycles want %h after 3", m1_rdata, gcyc, e.d);
            end
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL write_timeout: got no m1_ready want one");
      end
      cyc();
      m1_valid = 1'b0; m1_wstrb = 4'h0;
      cyc();
   endtask

   task automatic test_timeout();
      exp_t e;
      int   gcyc = 0;
      bit   seen = 1'b0;
      mem_lat = -1;
      m0_valid = 1'b1; m0_addr = 32'h200; m0_instr = 1'b1; m0_wstrb = 4'h0;
      sb.push_back({1'b0, 32'hDEAD_BEEF});
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         if (grant === 2'b01) gcyc++;
         n_cmp++;
         if (timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL tmo_early_err: got %b want 0", timeout_err);
         end
         if (m0_ready === 1'b1) begin
            seen = 1'b1;
            n_cmp++;
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            if (e !== {1'b0, m0_rdata} || s_valid !== 1'b0 || gcyc != 5) begin
               n_bad++; $display("FAIL tmo_resp: got rdata=%h s_valid=%b cycles=%0d want %h 0 5",
                                 m0_rdata, s_valid, gcyc, e.d);
            end
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL tmo_no_ready: got no m0_ready want one");
      end
      cyc();
      m0_valid = 1'b0; m0_instr = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b1 || grant !== 2'b00) begin
         n_bad++; $display("FAIL tmo_err_set: got err=%b grant=%b want 1 00", timeout_err, grant);
      end
      mem_lat = 1; seen = 1'b0;
      m1_valid = 1'b1; m1_addr = 32'h300;
      sb.push_back({1'b1, mem_val(32'h300)});
      for (int i = 0; i < 10 && !seen; i++) begin
         cyc();
         if (m1_ready === 1'b1) begin
            seen = 1'b1;
            n_cmp++;
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            if (e !== {1'b1, m1_rdata}) begin
               n_bad++; $display("FAIL tmo_next_m1: got %h want %h", m1_rdata, e.d);
            end
         end
      end
      cyc();
      m1_valid = 1'b0;
      n_cmp++;
      if (!seen || timeout_err !== 1'b1) begin
         n_bad++; $display("FAIL tmo_sticky: got seen=%b err=%b want 1 1", seen, timeout_err);
      end
   endtask

   task automatic test_tie();
      exp_t e;
      int   gcyc = 0;
      bit   seen = 1'b0;
      resn = 1'b0;
      cyc(); cyc();
      resn = 1'b1;
      cyc();
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_bad++; $display("FAIL tie_err_cleared: got %b want 0", timeout_err);
      end
      mem_lat = 4;
      m1_valid = 1'b1; m1_addr = 32'h44;
      sb.push_back({1'b1, mem_val(32'h44)});
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         if (grant === 2'b10) gcyc++;
         if (m1_ready === 1'b1) begin
            seen = 1'b1;
            n_cmp++;
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            if (e !== {1'b1, m1_rdata} || gcyc != 5) begin
               n_bad++; $display("FAIL tie_resp: got %h after %0d cycles want %h after 5", m1_rdata, gcyc, e.d);
            end
         end
      end
      cyc();
      m1_valid = 1'b0;
      n_cmp++;
      if (!seen || timeout_err !== 1'b0) begin
         n_bad++; $display("FAIL tie_err: got seen=%b err=%b want 1 0", seen, timeout_err);
      end
      cyc();
   endtask

   task automatic test_violation();
      exp_t e;
      mem_lat = 0;
      m0_valid = 1'b1; m0_addr = 32'h500;
      cyc();
      m0_valid = 1'b0;
      #1;
      n_cmp++;
      if (grant !== 2'b01 || m0_ready !== 1'b0) begin
         n_bad++; $display("FAIL viol_drop: got grant=%b m0_ready=%b want 01 0", grant, m0_ready);
      end
      m0_valid = 1'b1; m1_valid = 1'b1; m1_addr = 32'h600;
      cyc();
      n_cmp++;
      if (grant !== 2'b00) begin
         n_bad++; $display("FAIL viol_idle: got %b want 00", grant);
      end
      sb.push_back({1'b1, mem_val(32'h600)});
      cyc();
      n_cmp++;
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      if (grant !== 2'b10 || m1_ready !== 1'b1 || e !== {1'b1, m1_rdata}) begin
         n_bad++; $display("FAIL viol_rr: got grant=%b m1_ready=%b m1=%h want 10 1 %h", grant, m1_ready, m1_rdata, e.d);
      end
      cyc();
      m0_valid = 1'b0; m1_valid = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   hit = 1'b0;
      mem_lat = -1;
      m1_valid = 1'b1; m1_addr = 32'h80;
      for (int i = 0; i < 6 && !hit; i++) begin
         cyc();
         if (grant === 2'b10) hit = 1'b1;
      end
      cyc();
      resn = 1'b0;
      #1;
      n_cmp++;
      if (!hit || {s_valid, s_addr, m0_ready, m1_ready, m1_rdata, grant, timeout_err} !== '0) begin
         n_bad++; $display("FAIL rmid_during: got hit=%b s_valid=%b grant=%b m1_ready=%b want 1 0 00 0",
                           hit, s_valid, grant, m1_ready);
      end
      cyc();
      n_cmp++;
      if ({s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata, grant, timeout_err} !== '0) begin
         n_bad++; $display("FAIL rmid_after: got s_valid=%b grant=%b m1_ready=%b want all zero", s_valid, grant, m1_ready);
      end
      m0_valid = 1'b1; m0_addr = 32'h90; mem_lat = 0;
      resn = 1'b1;
      sb.push_back({1'b0, mem_val(32'h90)});
      cyc();
      n_cmp++;
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      if (grant !== 2'b01 || m0_ready !== 1'b1 || e !== {1'b0, m0_rdata}) begin
         n_bad++; $display("FAIL rmid_m0_first: got grant=%b m0_ready=%b m0=%h want 01 1 %h", grant, m0_ready, m0_rdata, e.d);
      end
      cyc();
      m0_valid = 1'b0; m1_valid = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_write();
      test_timeout();
      test_tie();
      test_violation();
      test_reset_mid();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
